// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO interrupt controller: register map, channel limit,
// and byte-lane helpers used by the Wishbone register file.
package gpio_pkg;

    localparam int unsigned MAX_IO = 32;

    // Register index = wb_adr_i[4:2]; byte offset = index * 4
    typedef enum logic [2:0] {
        RegDout     = 3'd0,
        RegDir      = 3'd1,
        RegDin      = 3'd2,
        RegRiseEn   = 3'd3,
        RegFallEn   = 3'd4,
        RegStatus   = 3'd5,
        RegDebLimit = 3'd6,
        RegRsvd     = 3'd7
    } reg_sel_e;

    localparam logic [4:0] OFS_DOUT      = 5'h00;
    localparam logic [4:0] OFS_DIR       = 5'h04;
    localparam logic [4:0] OFS_DIN       = 5'h08;
    localparam logic [4:0] OFS_RISE_EN   = 5'h0C;
    localparam logic [4:0] OFS_FALL_EN   = 5'h10;
    localparam logic [4:0] OFS_STATUS    = 5'h14;
    localparam logic [4:0] OFS_DEB_LIMIT = 5'h18;
    localparam logic [4:0] OFS_RSVD      = 5'h1C;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[b*8 +: 8] = {8{sel[b]}};
        end
        return mask;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] mask;
        mask = byte_mask(sel);
        return (new_val & mask) | (old_val & ~mask);
    endfunction

endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// Wishbone classic slave bus bundle for the GPIO interrupt controller.
interface gpio_irq_ctrl_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/gpio_debounce_ch.sv
// One GPIO input channel: 2-flop synchroniser, tick-based debouncer holding the stable
// value, and one-cycle rise/fall pulses derived from changes of that stable value.
module gpio_debounce_ch (
    input  logic clk,
    input  logic reset_n,
    input  logic pad_i,
    input  logic tick_i,
    input  logic bypass_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q, sync2_q;
    logic samp_q;
    logic stable_q, stable_d;

    // Edges are taken from the next-state so the status register sees them one cycle
    // after the synchroniser output changes.
    always_comb begin
        stable_d = stable_q;
        if (bypass_i) begin
            stable_d = sync2_q;
        end else if (tick_i && (sync2_q == samp_q)) begin
            stable_d = sync2_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            samp_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= pad_i;
            sync2_q  <= sync1_q;
            if (tick_i) begin
                samp_q <= sync2_q;
            end
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = stable_d & ~stable_q;
    assign fall_o   = ~stable_d & stable_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO controller with Wishbone register file, debounced inputs, per-channel edge
// interrupt enables, sticky W1C status and a registered level interrupt.
module gpio_irq_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_IO = 32,
    parameter int unsigned DEB_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    gpio_irq_ctrl_if.slave    bus,
    input  logic [NUM_IO-1:0] io_i,
    output logic [NUM_IO-1:0] io_o,
    output logic [NUM_IO-1:0] io_oe,
    output logic              irq_o
);

    reg_sel_e          sel_reg;
    logic              req, wr;
    logic              ack_q;
    logic [31:0]       rdata, rdata_q, wdata;
    logic [NUM_IO-1:0] dout_q, dir_q, rise_en_q, fall_en_q;
    logic [NUM_IO-1:0] status_q, status_d, status_set, status_clr;
    logic [NUM_IO-1:0] stable, rise, fall;
    logic [DEB_W-1:0]  deb_limit_q, cnt_q, cnt_d;
    logic              tick, bypass;
    logic              irq_q;
    logic              unused_adr;

    assign unused_adr = ^bus.wb_adr_i[1:0];

    // A request is taken only when no ack is outstanding, so a held strobe acks every
    // other cycle.
    assign req     = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
    assign wr      = req & bus.wb_we_i;
    assign sel_reg = reg_sel_e'(bus.wb_adr_i[4:2]);

    always_comb begin
        rdata = '0;
        unique case (sel_reg)
            RegDout:     rdata = 32'(dout_q);
            RegDir:      rdata = 32'(dir_q);
            RegDin:      rdata = 32'(stable);
            RegRiseEn:   rdata = 32'(rise_en_q);
            RegFallEn:   rdata = 32'(fall_en_q);
            RegStatus:   rdata = 32'(status_q);
            RegDebLimit: rdata = 32'(deb_limit_q);
            RegRsvd:     rdata = '0;
            default:     rdata = '0;
        endcase
    end

    assign wdata = byte_merge(rdata, bus.wb_dat_i, bus.wb_sel_i);

    // Prescaler: 0..DEB_LIMIT, tick on wrap, restarted by any DEB_LIMIT write
    assign tick   = (cnt_q == deb_limit_q);
    assign bypass = (deb_limit_q == '0);

    always_comb begin
        if (wr && (sel_reg == RegDebLimit)) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_IO; i++) begin : g_ch
        gpio_debounce_ch u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .pad_i    (io_i[i]),
            .tick_i   (tick),
            .bypass_i (bypass),
            .stable_o (stable[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
        );
    end

    // New events take priority over a simultaneous write-1-to-clear
    assign status_set = (rise & rise_en_q) | (fall & fall_en_q);
    assign status_clr = (wr && (sel_reg == RegStatus)) ?
                        NUM_IO'(bus.wb_dat_i & byte_mask(bus.wb_sel_i)) : '0;
    assign status_d   = (status_q & ~status_clr) | status_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            dout_q      <= '0;
            dir_q       <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            deb_limit_q <= '0;
            cnt_q       <= '0;
            status_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            ack_q   <= req;
            rdata_q <= req ? rdata : '0;
            if (wr) begin
                unique case (sel_reg)
                    RegDout:     dout_q      <= NUM_IO'(wdata);
                    RegDir:      dir_q       <= NUM_IO'(wdata);
                    RegRiseEn:   rise_en_q   <= NUM_IO'(wdata);
                    RegFallEn:   fall_en_q   <= NUM_IO'(wdata);
                    RegDebLimit: deb_limit_q <= DEB_W'(wdata);
                    default:     ;
                endcase
            end
            cnt_q    <= cnt_d;
            status_q <= status_d;
            irq_q    <= |status_q;
        end
    end

    assign bus.wb_ack_o = ack_q;
    assign bus.wb_dat_o = rdata_q;
    assign io_o         = dout_q;
    assign io_oe        = dir_q;
    assign irq_o        = irq_q;

endmodule

// File: doc/gpio_irq_ctrl.md
GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

Interface
REQ-001 Parameter NUM_IO, default 32, number of GPIO channels (1..32).
REQ-002 Parameter DEB_W, default 16, width of debounce prescaler and DEB_LIMIT register.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone classic slave request.
REQ-006 wb_adr_i  input  5  byte address; bits [4:2] select register, [1:0] ignored.
REQ-007 wb_dat_i  input  32  write data; wb_sel_i  input  4  byte enables.
REQ-008 wb_dat_o  output  32  read data; wb_ack_o  output  1  transfer acknowledge.
REQ-009 io_i  input  NUM_IO  pad input; io_o  output  NUM_IO  pad output; io_oe  output  NUM_IO  output enable, 1 = drive.
REQ-010 irq_o  output  1  level interrupt to core.

Function
REQ-011 Register map: 0x00 DOUT (RW), 0x04 DIR (RW, 1 = output), 0x08 DIN (RO, debounced input), 0x0C RISE_EN (RW), 0x10 FALL_EN (RW), 0x14 STATUS (RW1C), 0x18 DEB_LIMIT (RW, DEB_W bits), 0x1C reserved (reads 0, writes ignored).
REQ-012 Bus: wb_ack_o asserts exactly one cycle after cycle with wb_cyc_i & wb_stb_i & !wb_ack_o; single-cycle pulse; no wait states; back-to-back requests ack every other cycle.
REQ-013 Writes honour wb_sel_i per byte; bits at or above NUM_IO read 0 and are not writable.
REQ-014 wb_dat_o valid in the ack cycle, 0 otherwise.
REQ-015 io_o = DOUT, io_oe = DIR, combinationally from registers; DOUT write visible on io_o the cycle after ack.
REQ-016 io_i passes a 2-flop synchroniser per channel before any use.
REQ-017 Prescaler counts 0..DEB_LIMIT, emits one-cycle tick on wrap; DEB_LIMIT write restarts prescaler at 0.
REQ-018 Each channel: on tick, sample synchronised input; stable value updates only when two consecutive tick samples agree.
REQ-019 DEB_LIMIT = 0: debounce bypassed, stable value = synchronised input each cycle.
REQ-020 DIN returns stable value for all channels regardless of DIR.
REQ-021 Edge detect on stable value: rise = 0->1, fall = 1->0, one-cycle pulse per change.
REQ-022 STATUS[i] sets on (rise & RISE_EN[i]) | (fall & FALL_EN[i]); cleared by writing 1; set wins over simultaneous clear.
REQ-023 irq_o registered: irq_o = |STATUS, one cycle after STATUS changes; clearing all enables does not clear STATUS.
REQ-024 Input-to-irq latency with DEB_LIMIT = 0: 4 cycles after io_i edge (2 sync, 1 edge/status, 1 irq).

Reset
REQ-025 reset_n low: all registers, synchroniser flops, stable values, prescaler, STATUS cleared to 0; DEB_LIMIT resets to 0; wb_ack_o, wb_dat_o, irq_o, io_o, io_oe 0.
REQ-026 Reset deassertion mid-transfer: pending request not acked; first ack only for a request seen after release.
REQ-027 Stable value starts at 0; a pad held high through reset produces one rise edge after release.

Structure
REQ-028 Shared package gpio_pkg holds register offset constants and the NUM_IO maximum.
REQ-029 Sub-module gpio_debounce_ch (synchroniser, tick sampler, stable value, edge pulses) instantiated NUM_IO times via generate; bus, registers, prescaler, IRQ logic in top.

Verification
REQ-030 Write 0x0000_00FF to DIR, 0xA5 to DOUT -> io_oe = 0xFF, io_o[7:0] = 0xA5 next cycle; readback matches.
REQ-031 DEB_LIMIT = 0, RISE_EN[3] = 1, io_i[3] 0->1 -> STATUS = 0x8, irq_o high 4 cycles later; write 0x8 to STATUS -> irq_o low next cycle+1.
REQ-032 DEB_LIMIT = 9, glitch io_i[0] high for 5 cycles -> DIN[0] stays 0, no STATUS; hold high 40 cycles -> DIN[0] = 1.
REQ-033 FALL_EN[1] = 1, W1C of STATUS[1] in same cycle as new falling edge -> STATUS[1] remains 1.
REQ-034 Write wb_sel_i = 0b0010, data 0xFFFF_FFFF to DOUT = 0 -> DOUT = 0x0000_FF00.
REQ-035 Assert reset_n low mid-transfer with STATUS = 0xF -> all outputs 0, no ack, STATUS = 0 after release.
